pulse_burst_sched: RTL and testbench
====================================

Name: pulse_burst_sched

Overview:
- Round-robin scheduler that shares one short-pulse output channel between N_REQ requesters.
- Each requester asks for a burst of pulses and supplies its own pulse width, period and pulse count.
- The block grants one requester at a time and generates that burst on the shared pulse line.
- It signals completion with done/done_id, then re-arbitrates. It sits between the control logic and the pulse output pin.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- CNT_W, 8, width of the per-requester width/period fields, in clock cycles.
- BURST_W, 4, width of the per-requester pulse-count field.
- ID_W, 2, width of done_id; must equal clog2(N_REQ), and N_REQ=4 gives ID_W=2.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  level request, one bit per requester; must stay high until done.
- cfg_width  in  N_REQ*CNT_W  pulse high time per requester; slice i = bits [i*CNT_W +: CNT_W].
- cfg_period  in  N_REQ*CNT_W  pulse repetition period per requester.
- cfg_count  in  N_REQ*BURST_W  number of pulses per burst.
- grant  out  N_REQ  one-hot owner of the channel; all zero when idle.
- busy  out  1  high whenever state is not IDLE.
- pulse  out  1  shared pulse output.
- done  out  1  one-cycle strobe when the granted burst completes normally.
- done_id  out  ID_W  index of the finished requester; valid only while done=1.

Behaviour:
- Reset: on any rising clk edge with rst=1, all outputs go to 0, state goes to IDLE, rr_ptr goes to 0, and internal counters clear. This includes reset arriving mid-burst.
- All outputs are registered and driven directly from state/counter flops.
- States: IDLE, HIGH, LOW, DONE.
- IDLE arbitration:
  - Select the first asserted req bit searching from rr_ptr upward, wrapping modulo N_REQ.
  - On the edge: latch that requester's width/period/count, set grant one-hot, go to HIGH (count>0) or DONE (count=0).
  - Pulse is first high in the cycle after req is sampled in IDLE (latency 1).
- Config normalisation at latch time:
  - w_eff = max(width,1).
  - p_eff = max(period, w_eff+1), so there is at least one low cycle between pulses.
  - Config changes during a burst are ignored.
- HIGH: pulse=1 for exactly w_eff cycles, then decrement the remaining count.
  - If the remaining count becomes 0, go to DONE.
  - Otherwise go to LOW.
- LOW: pulse=0 for exactly p_eff-w_eff cycles, then go to HIGH.
- DONE: single cycle.
  - done=1, done_id=granted index, pulse=0, grant still held.
  - Next state IDLE; grant clears; rr_ptr becomes granted index+1 mod N_REQ.
- IDLE always lasts at least one cycle between bursts, including back-to-back requests from the same or other requesters.
- Abort: if the granted req bit is sampled low in HIGH or LOW:
  - Next cycle state is IDLE and pulse, grant and busy are 0.
  - done stays 0.
  - rr_ptr advances as on completion.
- Non-granted req changes never affect the active burst.
- Width arithmetic: the phase counter is CNT_W bits and never wraps. The p_eff computation uses CNT_W+1 bits; if w_eff = 2^CNT_W-1, then p_eff = 2^CNT_W.
- Simultaneous requests resolve purely by rr_ptr order. Any requester with req held continuously is served within N_REQ bursts (no starvation).

Decomposition:
- Package pulse_sched_pkg holds:
  - state enum type (IDLE/HIGH/LOW/DONE);
  - default CNT_W/BURST_W constants;
  - a function that normalises width/period.
- One natural sub-module: rr_arbiter.
  - Inputs: req and rr_ptr.
  - Outputs: one-hot grant_next and its index.
  - Purely combinational, reusable elsewhere.
- The burst FSM and counters stay in pulse_burst_sched.

Test Plan:
- Single burst: req0=1, width=2, period=5, count=3, request sampled in cycle k.
  - pulse=1 in cycles k+1..k+2, k+6..k+7 and k+11..k+12.
  - done=1 with done_id=0 in cycle k+13.
  - grant=0001 through k+13, then 0000 at k+14.
- Round-robin: req=1111 held, all count=1, width=1, period=2.
  - done_id sequence is 0,1,2,3,0.
  - Each burst is separated by one IDLE cycle.
- Normalisation: width=0, period=0, count=2.
  - Pulses high for 1 cycle and low for 1 cycle: pattern 1,0,1.
  - done follows the second pulse.
- Zero count: count=0 on req2.
  - grant=0100 for one cycle, no pulse, done=1 with done_id=2.
- Abort: req1 dropped during the second HIGH phase of a count=4 burst.
  - pulse=0, grant=0, busy=0 on the next cycle; done is never asserted.
  - The next grant goes to requester 2 or higher.
- Reset mid-burst: rst=1 for one cycle during a HIGH phase.
  - All outputs are 0 after that edge.
  - With req held, the next grant goes to requester 0.

Source files
------------

// File: rtl/pulse_sched_pkg.sv
// Shared types, default sizes and config normalisation helpers for the pulse burst scheduler.
package pulse_sched_pkg;

  localparam int unsigned DefNReq   = 4;
  localparam int unsigned DefCntW   = 8;
  localparam int unsigned DefBurstW = 4;
  localparam int unsigned DefIdW    = 2;

  typedef enum logic [1:0] {
    StIdle,
    StHigh,
    StLow,
    StDone
  } state_e;

  function automatic int unsigned norm_width(input int unsigned width);
    return (width == 0) ? 1 : width;
  endfunction

  // Low-phase length p_eff - w_eff; always at least one cycle so pulses never merge.
  function automatic int unsigned norm_low_len(input int unsigned w_eff,
                                               input int unsigned period);
    int unsigned p_eff;
    p_eff = (period > w_eff) ? period : w_eff + 1;
    return p_eff - w_eff;
  endfunction

endpackage

// File: rtl/pulse_burst_sched_if.sv
// Request/config/pulse bundle between the control logic and the burst scheduler.
interface pulse_burst_sched_if #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned BURST_W = 4,
  parameter int unsigned ID_W    = 2
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*CNT_W-1:0]   cfg_width;
  logic [N_REQ*CNT_W-1:0]   cfg_period;
  logic [N_REQ*BURST_W-1:0] cfg_count;
  logic [N_REQ-1:0]         grant;
  logic                     busy;
  logic                     pulse;
  logic                     done;
  logic [ID_W-1:0]          done_id;

  modport master (
    output req, cfg_width, cfg_period, cfg_count,
    input  grant, busy, pulse, done, done_id
  );

  modport slave (
    input  req, cfg_width, cfg_period, cfg_count,
    output grant, busy, pulse, done, done_id
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or above ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             valid_o
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < N_REQ; off++) begin
      cand = ID_W'((32'(ptr_i) + off) % N_REQ);
      if (!valid_o && req_i[cand]) begin
        valid_o       = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/pulse_burst_sched.sv
// Round-robin burst scheduler: grants one requester at a time and plays its pulse burst
// on the shared pulse line; all outputs come straight from flops.
module pulse_burst_sched
  import pulse_sched_pkg::*;
#(
  parameter int unsigned N_REQ   = DefNReq,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned BURST_W = DefBurstW,
  parameter int unsigned ID_W    = DefIdW
) (
  input logic               clk,
  input logic               rst,
  pulse_burst_sched_if.slave bus
);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     phase_q, phase_d;
  logic [CNT_W-1:0]     w_eff_q, w_eff_d;
  logic [CNT_W-1:0]     low_len_q, low_len_d;
  logic [BURST_W-1:0]   rem_q, rem_d;
  logic [ID_W-1:0]      idx_q, idx_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 pulse_q, pulse_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [ID_W-1:0]      done_id_q, done_id_d;

  logic [N_REQ-1:0]     arb_grant;
  logic [ID_W-1:0]      arb_idx;
  logic                 arb_valid;

  logic [CNT_W-1:0]     width_arr  [N_REQ];
  logic [CNT_W-1:0]     period_arr [N_REQ];
  logic [BURST_W-1:0]   count_arr  [N_REQ];
  logic [CNT_W-1:0]     sel_width, sel_period;
  logic [BURST_W-1:0]   sel_count;
  int unsigned          sel_w_eff;
  logic [ID_W-1:0]      ptr_after;
  logic                 owner_req;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i   (bus.req),
    .ptr_i   (rr_ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      width_arr[i]  = bus.cfg_width[i*CNT_W +: CNT_W];
      period_arr[i] = bus.cfg_period[i*CNT_W +: CNT_W];
      count_arr[i]  = bus.cfg_count[i*BURST_W +: BURST_W];
    end
  end

  assign sel_width  = width_arr[arb_idx];
  assign sel_period = period_arr[arb_idx];
  assign sel_count  = count_arr[arb_idx];
  assign sel_w_eff  = norm_width(32'(sel_width));
  assign ptr_after  = (idx_q == ID_W'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
  assign owner_req  = bus.req[idx_q];

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    w_eff_d   = w_eff_q;
    low_len_d = low_len_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    pulse_d   = 1'b0;
    done_d    = 1'b0;
    done_id_d = '0;

    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          w_eff_d   = CNT_W'(sel_w_eff);
          low_len_d = CNT_W'(norm_low_len(sel_w_eff, 32'(sel_period)));
          rem_d     = sel_count;
          idx_d     = arb_idx;
          grant_d   = arb_grant;
          busy_d    = 1'b1;
          if (sel_count == '0) begin
            state_d   = StDone;
            done_d    = 1'b1;
            done_id_d = arb_idx;
          end else begin
            state_d = StHigh;
            pulse_d = 1'b1;
            phase_d = CNT_W'(sel_w_eff - 1);
          end
        end
      end
      StHigh, StLow: begin
        if (!owner_req) begin
          // Owner withdrew: drop the channel silently, no done strobe.
          state_d  = StIdle;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = ptr_after;
        end else if (state_q == StHigh) begin
          if (phase_q == '0) begin
            rem_d = rem_q - 1'b1;
            if (rem_q == BURST_W'(1)) begin
              state_d   = StDone;
              done_d    = 1'b1;
              done_id_d = idx_q;
            end else begin
              state_d = StLow;
              phase_d = low_len_q - 1'b1;
            end
          end else begin
            pulse_d = 1'b1;
            phase_d = phase_q - 1'b1;
          end
        end else begin
          if (phase_q == '0) begin
            state_d = StHigh;
            pulse_d = 1'b1;
            phase_d = w_eff_q - 1'b1;
          end else begin
            phase_d = phase_q - 1'b1;
          end
        end
      end
      StDone: begin
        state_d  = StIdle;
        grant_d  = '0;
        busy_d   = 1'b0;
        rr_ptr_d = ptr_after;
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      phase_q   <= '0;
      w_eff_q   <= '0;
      low_len_q <= '0;
      rem_q     <= '0;
      idx_q     <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      w_eff_q   <= w_eff_d;
      low_len_q <= low_len_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.busy    = busy_q;
  assign bus.pulse   = pulse_q;
  assign bus.done    = done_q;
  assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_pulse_burst_sched.sv
// Directed bench for pulse_burst_sched with hand-computed per-cycle expectations.
module tb_pulse_burst_sched;

  localparam int unsigned NReq   = 4;
  localparam int unsigned CntW   = 8;
  localparam int unsigned BurstW = 4;
  localparam int unsigned IdW    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  pulse_burst_sched_if #(
    .N_REQ   (NReq),
    .CNT_W   (CntW),
    .BURST_W (BurstW),
    .ID_W    (IdW)
  ) bus ();

  pulse_burst_sched #(
    .N_REQ   (NReq),
    .CNT_W   (CntW),
    .BURST_W (BurstW),
    .ID_W    (IdW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int i, input int w, input int p, input int c);
    bus.cfg_width[i*CntW +: CntW]       = CntW'(w);
    bus.cfg_period[i*CntW +: CntW]      = CntW'(p);
    bus.cfg_count[i*BurstW +: BurstW]   = BurstW'(c);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_grant"}, 32'(bus.grant), 32'd0);
    check({tag, "_busy"},  32'(bus.busy),  32'd0);
    check({tag, "_pulse"}, 32'(bus.pulse), 32'd0);
    check({tag, "_done"},  32'(bus.done),  32'd0);
  endtask

  logic [14:1]    pexp, dexp, gexp;
  logic [IdW-1:0] id;

  initial begin
    bus.req        = '0;
    bus.cfg_width  = '0;
    bus.cfg_period = '0;
    bus.cfg_count  = '0;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset");
    check("reset_done_id", 32'(bus.done_id), 32'd0);
    rst = 1'b0;

    // Single burst: w=2 p=5 c=3 on requester 0
    set_cfg(0, 2, 5, 3);
    bus.req = 4'b0001;
    pexp = 14'b00110001100011;
    dexp = 14'b01000000000000;
    gexp = 14'b01111111111111;
    for (int j = 1; j <= 14; j++) begin
      tick();
      check($sformatf("single_pulse_c%0d", j), 32'(bus.pulse), 32'(pexp[j]));
      check($sformatf("single_done_c%0d", j), 32'(bus.done), 32'(dexp[j]));
      check($sformatf("single_grant_c%0d", j), 32'(bus.grant), gexp[j] ? 32'd1 : 32'd0);
      check($sformatf("single_busy_c%0d", j), 32'(bus.busy), 32'(gexp[j]));
      if (j == 13) begin
        check("single_done_id", 32'(bus.done_id), 32'd0);
        bus.req = 4'b0000;
      end
    end

    // Round-robin from a fresh pointer, all requesters held
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_cfg(i, 1, 2, 1);
    bus.req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      id = IdW'(b % 4);
      tick();
      check($sformatf("rr_pulse_b%0d", b), 32'(bus.pulse), 32'd1);
      check($sformatf("rr_grant_b%0d", b), 32'(bus.grant), 32'd1 << id);
      tick();
      check($sformatf("rr_done_b%0d", b), 32'(bus.done), 32'd1);
      check($sformatf("rr_done_id_b%0d", b), 32'(bus.done_id), 32'(id));
      if (b == 4) bus.req = 4'b0000;
      tick();
      check_idle($sformatf("rr_gap_b%0d", b));
    end

    // Normalisation: width=0 period=0 count=2 on requester 1 (pointer now 1)
    set_cfg(1, 0, 0, 2);
    bus.req = 4'b0010;
    tick();
    check("norm_p1", 32'(bus.pulse), 32'd1);
    check("norm_grant", 32'(bus.grant), 32'h2);
    tick();
    check("norm_p2", 32'(bus.pulse), 32'd0);
    check("norm_busy", 32'(bus.busy), 32'd1);
    tick();
    check("norm_p3", 32'(bus.pulse), 32'd1);
    tick();
    check("norm_done", 32'(bus.done), 32'd1);
    check("norm_done_id", 32'(bus.done_id), 32'd1);
    check("norm_done_pulse", 32'(bus.pulse), 32'd0);
    bus.req = 4'b0000;
    tick();
    check_idle("norm_after");

    // Zero count on requester 2
    set_cfg(2, 5, 9, 0);
    bus.req = 4'b0100;
    tick();
    check("zero_grant", 32'(bus.grant), 32'h4);
    check("zero_done", 32'(bus.done), 32'd1);
    check("zero_done_id", 32'(bus.done_id), 32'd2);
    check("zero_pulse", 32'(bus.pulse), 32'd0);
    bus.req = 4'b0000;
    tick();
    check_idle("zero_after");

    // Abort: requester 1 (w=2 p=4 c=4) drops during its second high phase
    set_cfg(1, 2, 4, 4);
    set_cfg(2, 1, 2, 1);
    bus.req = 4'b0110;
    tick();
    check("abort_grant", 32'(bus.grant), 32'h2);
    check("abort_t1", 32'(bus.pulse), 32'd1);
    tick();
    check("abort_t2", 32'(bus.pulse), 32'd1);
    tick();
    check("abort_t3", 32'(bus.pulse), 32'd0);
    tick();
    check("abort_t4", 32'(bus.pulse), 32'd0);
    tick();
    check("abort_t5", 32'(bus.pulse), 32'd1);
    bus.req = 4'b0101;
    tick();
    check_idle("abort_t6");
    tick();
    check("abort_next_grant", 32'(bus.grant), 32'h4);
    check("abort_next_pulse", 32'(bus.pulse), 32'd1);
    tick();
    check("abort_next_done_id", 32'(bus.done_id), 32'd2);
    check("abort_next_done", 32'(bus.done), 32'd1);
    bus.req = 4'b0000;
    tick();
    check_idle("abort_after");

    // Reset during a high phase; pointer must return to 0
    set_cfg(3, 3, 6, 2);
    bus.req = 4'b1001;
    tick();
    check("rstmid_grant", 32'(bus.grant), 32'h8);
    check("rstmid_pulse", 32'(bus.pulse), 32'd1);
    rst = 1'b1;
    tick();
    check_idle("rstmid_after");
    check("rstmid_done_id", 32'(bus.done_id), 32'd0);
    rst = 1'b0;
    tick();
    check("rstmid_regrant", 32'(bus.grant), 32'h1);
    check("rstmid_repulse", 32'(bus.pulse), 32'd1);
    bus.req = 4'b0000;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    check_idle("rstmid_clear");

    // Width at maximum: period forced to 2^CNT_W, so exactly one low cycle
    set_cfg(0, 255, 10, 2);
    bus.req = 4'b0001;
    for (int j = 1; j <= 512; j++) begin
      tick();
      if (j == 1 || j == 255 || j == 257 || j == 511)
        check($sformatf("wmax_high_c%0d", j), 32'(bus.pulse), 32'd1);
      if (j == 256) begin
        check("wmax_low_pulse", 32'(bus.pulse), 32'd0);
        check("wmax_low_busy", 32'(bus.busy), 32'd1);
      end
      if (j == 512) begin
        check("wmax_done", 32'(bus.done), 32'd1);
        check("wmax_done_pulse", 32'(bus.pulse), 32'd0);
        bus.req = 4'b0000;
      end
    end
    tick();
    check_idle("wmax_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
